// File: rtl/instr_enc_loader.sv
// Program loader: re-encodes decoded control word + immediate pairs into RV32I
// instruction words and streams them into instruction memory from a base address.
module instr_enc_loader #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned CNT_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [22:0]       in_cword,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  word_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 7;

  localparam logic [3:0] IT_LOAD   = 4'd0;
  localparam logic [3:0] IT_IMM    = 4'd1;
  localparam logic [3:0] IT_STORE  = 4'd2;
  localparam logic [3:0] IT_R      = 4'd3;
  localparam logic [3:0] IT_LUI    = 4'd4;
  localparam logic [3:0] IT_AUIPC  = 4'd5;
  localparam logic [3:0] IT_BRANCH = 4'd6;
  localparam logic [3:0] IT_JALR   = 4'd7;
  localparam logic [3:0] IT_JAL    = 4'd8;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [4:0] rd;
    logic       fun7;
    logic [2:0] fun3;
    logic [3:0] itype;
  } cword_t;

  state_t            state, state_next;
  cword_t            cw;
  logic [XLEN-1:0]   enc;
  logic              valid_type;
  logic              is_shift;
  logic              accept;
  logic              overflow;
  logic              full;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt_inc;

  assign cw         = cword_t'(in_cword);
  assign valid_type = (cw.itype <= IT_JAL);
  assign is_shift   = (cw.fun3 == 3'b001) || (cw.fun3 == 3'b101);
  assign cnt_inc    = word_count + CNT_W'(1);
  assign overflow   = accept && valid_type && !in_last && (cnt_inc == CNT_W'(MAX_WORDS));

  // Instruction encoder: place control-word fields and immediate slices per format
  always_comb begin
    enc = '0;
    case (cw.itype)
      IT_LOAD:   enc = {in_imm[11:0], cw.rs1, cw.fun3, cw.rd, OP_LOAD};
      IT_IMM: begin
        if (is_shift)
          enc = {1'b0, cw.fun7, 5'b00000, in_imm[4:0], cw.rs1, cw.fun3, cw.rd, OP_IMM};
        else
          enc = {in_imm[11:0], cw.rs1, cw.fun3, cw.rd, OP_IMM};
      end
      IT_STORE:  enc = {in_imm[11:5], cw.rs2, cw.rs1, cw.fun3, in_imm[4:0], OP_STORE};
      IT_R:      enc = {1'b0, cw.fun7, 5'b00000, cw.rs2, cw.rs1, cw.fun3, cw.rd, OP_R};
      IT_LUI:    enc = {in_imm[31:12], cw.rd, OP_LUI};
      IT_AUIPC:  enc = {in_imm[31:12], cw.rd, OP_AUIPC};
      IT_BRANCH: enc = {in_imm[12], in_imm[10:5], cw.rs2, cw.rs1, cw.fun3,
                        in_imm[4:1], in_imm[11], OP_BRANCH};
      IT_JALR:   enc = {in_imm[11:0], cw.rs1, 3'b000, cw.rd, OP_JALR};
      IT_JAL:    enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], cw.rd, OP_JAL};
      default:   enc = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state and input handshake
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        in_ready = !full && (!mem_we || mem_ready);
        accept   = in_valid && in_ready;
        if (accept && (in_last || (valid_type && cnt_inc == CNT_W'(MAX_WORDS))))
          state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!mem_we || mem_ready) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: address/count tracking and the held write request
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      word_count <= '0;
      err        <= 1'b0;
      full       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy <= (state_next != S_IDLE);
      done <= (state_next == S_DONE);
      if (state == S_IDLE && start) begin
        addr       <= base_addr;
        word_count <= '0;
        err        <= 1'b0;
        full       <= 1'b0;
      end
      if (mem_we && mem_ready) mem_we <= 1'b0;
      // A new accept on the completing edge re-arms the write immediately
      if (accept) begin
        if (valid_type) begin
          mem_we     <= 1'b1;
          mem_addr   <= addr;
          mem_wdata  <= enc;
          addr       <= addr + ADDR_W'(4);
          word_count <= cnt_inc;
        end else begin
          err <= 1'b1;
        end
      end
      if (overflow) begin
        full <= 1'b1;
        err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_enc_loader.sv
// Randomized self-checking bench for instr_enc_loader against an arithmetic
// encoding model and a queue scoreboard of expected memory writes.
module tb_instr_enc_loader;

  localparam int unsigned MAXW = 4;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, mem_ready;
  logic [31:0] base_addr, in_imm;
  logic [22:0] in_cword;
  logic        in_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  word_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: forced low

  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          obs_cyc[$];

  logic [31:0] m_addr;
  int          m_cnt;
  bit          m_err, m_closed;

  int unsigned opc [0:8] = '{3, 19, 35, 51, 55, 23, 99, 103, 111};

  instr_enc_loader #(.ADDR_W(32), .MAX_WORDS(MAXW), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_cword(in_cword),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned fld(input logic [31:0] v, input int hi, input int lo);
    longint unsigned m;
    m = (64'd1 << (hi - lo + 1)) - 64'd1;
    return (longint'(v) >> lo) & m;
  endfunction

  // Reference encoder: fields placed by arithmetic shifts from the format tables
  function automatic logic [31:0] ref_enc(input logic [22:0] c, input logic [31:0] imm);
    longint unsigned t, f3, f7, rd, rs1, rs2, op, r;
    t = fld({9'd0, c}, 3, 0);   f3 = fld({9'd0, c}, 6, 4);  f7 = fld({9'd0, c}, 7, 7);
    rd = fld({9'd0, c}, 12, 8); rs1 = fld({9'd0, c}, 17, 13); rs2 = fld({9'd0, c}, 22, 18);
    r = 0;
    if (t > 8) return 32'd0;
    op = opc[int'(t)];
    case (t)
      0, 1, 7: begin
        if (t == 7) f3 = 0;
        if (t == 1 && (f3 == 1 || f3 == 5)) r = (f7 << 30) | (fld(imm, 4, 0) << 20);
        else r = fld(imm, 11, 0) << 20;
        r = r | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      2: r = (fld(imm, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | (fld(imm, 4, 0) << 7) | op;
      3: r = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      4, 5: r = (fld(imm, 31, 12) << 12) | (rd << 7) | op;
      6: r = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15)
             | (f3 << 12) | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | op;
      default: r = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
             | (fld(imm, 19, 12) << 12) | (rd << 7) | op;
    endcase
    return 32'(r);
  endfunction

  function automatic logic [22:0] mkcw(input int t, input int f3, input int f7,
                                       input int rd, input int rs1, input int rs2);
    return {5'(rs2), 5'(rs1), 5'(rd), 1'(f7), 3'(f3), 4'(t)};
  endfunction

  // mem_ready driver
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: mem_ready = 1'b1;
        1: mem_ready = ($urandom % 3) != 0;
        default: mem_ready = 1'b0;
      endcase
    end
  end

  // Write monitor: records completed writes, checks stability while stalled
  initial begin : monitor
    bit          h_pend;
    logic [31:0] h_addr, h_data;
    h_pend = 0; h_addr = '0; h_data = '0;
    forever begin
      @(negedge clk); #4;
      cyc++;
      if (rst) begin
        h_pend = 0;
      end else begin
        if (done) done_cnt++;
        if (h_pend) begin
          chk("hold_we", {63'd0, mem_we}, 64'd1);
          chk("hold_addr", {32'd0, mem_addr}, {32'd0, h_addr});
          chk("hold_data", {32'd0, mem_wdata}, {32'd0, h_data});
        end
        h_pend = mem_we && !mem_ready;
        h_addr = mem_addr;
        h_data = mem_wdata;
        if (mem_we && mem_ready) begin
          obs_q.push_back({mem_addr, mem_wdata});
          obs_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic model_accept(input logic [22:0] c, input logic [31:0] imm, input bit last);
    if (c[3:0] > 4'd8) begin
      m_err = 1;
    end else begin
      exp_q.push_back({m_addr, ref_enc(c, imm)});
      m_addr = m_addr + 32'd4;
      m_cnt++;
      if (m_cnt == MAXW && !last) begin
        m_err = 1;
        m_closed = 1;
      end
    end
    if (last) m_closed = 1;
  endtask

  task automatic send(input logic [22:0] c, input logic [31:0] imm, input bit last,
                      input int maxcyc, output bit acc);
    acc = 0;
    @(negedge clk);
    in_valid = 1'b1; in_cword = c; in_imm = imm; in_last = last;
    for (int n = 0; n < maxcyc; n++) begin
      #4;
      if (in_ready) acc = 1;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
    if (acc) model_accept(c, imm, last);
  endtask

  task automatic start_session(input logic [31:0] base);
    m_addr = base; m_cnt = 0; m_err = 0; m_closed = 0;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete(); done_cnt = 0;
    @(negedge clk);
    start = 1'b1; base_addr = base;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic end_session(input string tag);
    bit idle;
    idle = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); #4;
      if (!busy) begin idle = 1; break; end
    end
    chk({tag, "_idle"}, {63'd0, idle}, 64'd1);
    chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_write"}, obs_q[i], exp_q[i]);
    chk({tag, "_count"}, {61'd0, word_count}, 64'(m_cnt));
    chk({tag, "_err"}, {63'd0, err}, {63'd0, m_err});
    chk({tag, "_done"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic chk_obs(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] got;
    got = 'x;
    if (idx < obs_q.size()) got = obs_q[idx];
    chk(tag, got, {a, d});
  endtask

  task automatic check_zero(input string p);
    chk({p, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    chk({p, "_mem_we"}, {63'd0, mem_we}, 64'd0);
    chk({p, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
    chk({p, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
    chk({p, "_busy"}, {63'd0, busy}, 64'd0);
    chk({p, "_done"}, {63'd0, done}, 64'd0);
    chk({p, "_err"}, {63'd0, err}, 64'd0);
    chk({p, "_count"}, {61'd0, word_count}, 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit          acc;
    logic [22:0] c;
    int          nw, t;
    logic [31:0] base;
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_cword = '0; in_imm = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #4;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single addi x1,x0,5
    start_session(32'h100);
    send(mkcw(1, 0, 0, 1, 0, 0), 32'd5, 1, 20, acc);
    chk("basic_accept", {63'd0, acc}, 64'd1);
    end_session("basic");
    chk_obs("basic_word", 0, 32'h100, 32'h00500093);

    // Back-to-back with memory always ready
    start_session(32'h200);
    send(mkcw(3, 0, 1, 3, 1, 2), 32'd0, 0, 20, acc);
    send(mkcw(6, 0, 0, 0, 1, 2), 32'hFFFF_FFF8, 0, 20, acc);
    send(mkcw(8, 0, 0, 1, 0, 0), 32'h800, 0, 20, acc);
    send(mkcw(4, 0, 0, 5, 0, 0), 32'h1234_5000, 1, 20, acc);
    end_session("b2b");
    chk_obs("b2b_sub", 0, 32'h200, 32'h402081B3);
    chk_obs("b2b_beq", 1, 32'h204, 32'hFE208CE3);
    chk_obs("b2b_jal", 2, 32'h208, 32'h001000EF);
    chk_obs("b2b_lui", 3, 32'h20C, 32'h123452B7);
    for (int i = 1; i < obs_cyc.size(); i++)
      chk("b2b_rate", 64'(obs_cyc[i] - obs_cyc[0]), 64'(i));

    // Stall a pending write for three cycles
    start_session(32'h300);
    send(mkcw(2, 2, 0, 0, 3, 4), 32'h0000_07FC, 0, 20, acc);
    ready_mode = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #4;
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_mem_we", {63'd0, mem_we}, 64'd1);
      chk("stall_addr", {32'd0, mem_addr}, 64'h300);
    end
    ready_mode = 0;
    send(mkcw(0, 2, 0, 7, 8, 0), 32'hFFFF_F800, 1, 20, acc);
    end_session("stall");

    // Invalid type between two valid words
    start_session(32'h400);
    send(mkcw(1, 5, 1, 2, 3, 0), 32'h0000_0FE7, 0, 20, acc);
    send(mkcw(9, 0, 0, 1, 1, 1), 32'h1, 0, 20, acc);
    chk("inv_accept", {63'd0, acc}, 64'd1);
    send(mkcw(7, 3, 0, 1, 6, 0), 32'h0000_0123, 1, 20, acc);
    end_session("inv");
    chk("inv_err", {63'd0, err}, 64'd1);
    chk("inv_count", {61'd0, word_count}, 64'd2);
    chk_obs("inv_second", 1, 32'h404, 32'h123300E7);

    // Overflow: fifth word must never be accepted
    start_session(32'h500);
    for (int i = 0; i < 4; i++) send(mkcw(5, 0, 0, i + 1, 0, 0), 32'(i) << 12, 0, 20, acc);
    send(mkcw(1, 0, 0, 9, 9, 0), 32'd1, 0, 10, acc);
    chk("ovf_fifth", {63'd0, acc}, 64'd0);
    end_session("ovf");
    chk("ovf_count", {61'd0, word_count}, 64'd4);
    chk("ovf_err", {63'd0, err}, 64'd1);

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      ready_mode = int'($urandom_range(0, 1));
      base = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : $urandom;
      start_session(base);
      nw = int'($urandom_range(1, 6));
      for (int i = 0; i < nw && !m_closed; i++) begin
        t = ($urandom % 5 == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
        c = $urandom;
        c[3:0] = 4'(t);
        send(c, $urandom, (i == nw - 1), 100, acc);
        chk("rnd_accept", {63'd0, acc}, 64'd1);
      end
      end_session("rnd");
    end
    ready_mode = 0;

    // Reset in the middle of a session with a write pending
    ready_mode = 2;
    start_session(32'h600);
    send(mkcw(3, 7, 0, 4, 5, 6), 32'd0, 0, 20, acc);
    @(negedge clk); #4;
    chk("rstm_pending", {63'd0, mem_we}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    #4;
    check_zero("rstm");
    repeat (6) @(negedge clk);
    #4;
    chk("rstm_no_writes", 64'(obs_q.size()), 64'd0);
    chk("rstm_idle", {63'd0, busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
